// File: rtl/half_add_pkg.sv
// ============================================================================
// Module      : half_add_pkg
// Description : Shared defaults and result type for the half_add primitive.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package half_add_pkg;

   localparam int unsigned DEF_WIDTH = 1;
   localparam int unsigned DEF_CNT_W = 16;

   typedef struct packed {
      logic sum;
      logic carry;
   } ha_res_t;

   function automatic ha_res_t ha_eval(input logic a, input logic b);
      ha_res_t r;
      r.sum   = a ^ b;
      r.carry = a & b;
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/half_add_cell.sv
// ============================================================================
// Module      : half_add_cell
// Description : One-bit combinational half adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module half_add_cell
   import half_add_pkg::*;
(
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);

   ha_res_t w_res;

   assign w_res = ha_eval(a, b);
   assign sum   = w_res.sum;
   assign carry = w_res.carry;

endmodule

`default_nettype wire

// File: rtl/half_add.sv
// ============================================================================
// Module      : half_add
// Description : Bank of half-adder cells with combinational and registered,
//               valid-qualified results plus a saturating carry-event counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module half_add
   import half_add_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry,
   input  logic             in_valid,
   output logic [WIDTH-1:0] sum_q,
   output logic [WIDTH-1:0] carry_q,
   output logic             out_valid,
   output logic [CNT_W-1:0] carry_cnt,
   input  logic             cnt_clr
);

   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

   ha_res_t [WIDTH-1:0] w_res;
   logic    [WIDTH-1:0] w_sum;
   logic    [WIDTH-1:0] w_carry;
   logic                w_carry_evt;

   logic    [WIDTH-1:0] r_sum_q;
   logic    [WIDTH-1:0] r_carry_q;
   logic                r_out_valid;
   logic    [CNT_W-1:0] r_carry_cnt;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_cell
         half_add_cell u_cell (
            .a     (a[i]),
            .b     (b[i]),
            .sum   (w_res[i].sum),
            .carry (w_res[i].carry)
         );
         assign w_sum[i]   = w_res[i].sum;
         assign w_carry[i] = w_res[i].carry;
      end
   endgenerate

   assign w_carry_evt = in_valid & (|w_carry);

   // Result registers hold their contents while in_valid is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sum_q     <= '0;
         r_carry_q   <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_sum_q   <= w_sum;
            r_carry_q <= w_carry;
         end
      end
   end

   // Clear wins over increment; the count sticks at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_carry_cnt <= '0;
      end else if (cnt_clr) begin
         r_carry_cnt <= '0;
      end else if (w_carry_evt && (r_carry_cnt != c_cnt_max)) begin
         r_carry_cnt <= r_carry_cnt + c_cnt_one;
      end
   end

   assign sum       = w_sum;
   assign carry     = w_carry;
   assign sum_q     = r_sum_q;
   assign carry_q   = r_carry_q;
   assign out_valid = r_out_valid;
   assign carry_cnt = r_carry_cnt;

endmodule

`default_nettype wire

// File: tb/tb_half_add.sv
// ============================================================================
// Module      : tb_half_add
// Description : Self-checking bench for half_add (8-bit and 1-bit/2-bit-counter).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_half_add;

   localparam int c_max8 = 65535;
   localparam int c_max1 = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       run = 1'b0;
   logic       chk_en = 1'b0;

   logic [7:0] a8, b8, sum8, carry8, sq8, cq8;
   logic       v8, clr8, ov8;
   logic [15:0] cnt8;

   logic       a1, b1, sum1, carry1, sq1, cq1;
   logic       v1, clr1, ov1;
   logic [1:0] cnt1;

   int n_checks = 0;
   int n_fail   = 0;

   half_add #(.WIDTH(8), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .a(a8), .b(b8), .sum(sum8), .carry(carry8),
      .in_valid(v8), .sum_q(sq8), .carry_q(cq8), .out_valid(ov8),
      .carry_cnt(cnt8), .cnt_clr(clr8)
   );

   half_add #(.WIDTH(1), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .a(a1), .b(b1), .sum(sum1), .carry(carry1),
      .in_valid(v1), .sum_q(sq1), .carry_q(cq1), .out_valid(ov1),
      .carry_cnt(cnt1), .cnt_clr(clr1)
   );

   always begin
      #5;
      if (run) clk = ~clk;
   end

   // Behavioural model: bit-wise arithmetic, result bit = (a+b) mod 2, carry = (a+b) div 2.
   function automatic logic [7:0] exp_sum(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = ((int'(x[i]) + int'(y[i])) % 2) == 1;
      return r;
   endfunction

   function automatic logic [7:0] exp_carry(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = ((int'(x[i]) + int'(y[i])) / 2) == 1;
      return r;
   endfunction

   logic [7:0] m8_sq, m8_cq, m1_sq, m1_cq;
   logic       m8_v, m1_v;
   int         m8_cnt, m1_cnt;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m8_sq <= '0; m8_cq <= '0; m8_v <= 1'b0; m8_cnt <= 0;
         m1_sq <= '0; m1_cq <= '0; m1_v <= 1'b0; m1_cnt <= 0;
      end else begin
         m8_v <= v8;
         if (v8) begin
            m8_sq <= exp_sum(a8, b8);
            m8_cq <= exp_carry(a8, b8);
         end
         if (clr8) m8_cnt <= 0;
         else if (v8 && exp_carry(a8, b8) != 0) m8_cnt <= (m8_cnt < c_max8) ? m8_cnt + 1 : m8_cnt;
         m1_v <= v1;
         if (v1) begin
            m1_sq <= exp_sum({7'b0, a1}, {7'b0, b1});
            m1_cq <= exp_carry({7'b0, a1}, {7'b0, b1});
         end
         if (clr1) m1_cnt <= 0;
         else if (v1 && a1 && b1) m1_cnt <= (m1_cnt < c_max1) ? m1_cnt + 1 : m1_cnt;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cmp_sum8",   32'(sum8),   32'(exp_sum(a8, b8)));
         chk("cmp_carry8", 32'(carry8), 32'(exp_carry(a8, b8)));
         chk("cmp_sq8",    32'(sq8),    32'(m8_sq));
         chk("cmp_cq8",    32'(cq8),    32'(m8_cq));
         chk("cmp_ov8",    32'(ov8),    32'(m8_v));
         chk("cmp_cnt8",   32'(cnt8),   32'(m8_cnt));
         chk("cmp_sum1",   32'(sum1),   32'(exp_sum({7'b0, a1}, {7'b0, b1})));
         chk("cmp_carry1", 32'(carry1), 32'(exp_carry({7'b0, a1}, {7'b0, b1})));
         chk("cmp_sq1",    32'(sq1),    32'(m1_sq));
         chk("cmp_cq1",    32'(cq1),    32'(m1_cq));
         chk("cmp_ov1",    32'(ov1),    32'(m1_v));
         chk("cmp_cnt1",   32'(cnt1),   32'(m1_cnt));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   logic [1:0] tt_exp [4] = '{2'b00, 2'b10, 2'b10, 2'b01};
   logic [7:0] ca [5] = '{8'h01, 8'h01, 8'hFF, 8'h00, 8'h0F};
   logic [7:0] cb [5] = '{8'h01, 8'h02, 8'h80, 8'h00, 8'h01};

   initial begin
      rst = 1'bx;
      a8 = '0; b8 = '0; v8 = 1'b0; clr8 = 1'b0;
      a1 = 1'b0; b1 = 1'b0; v1 = 1'b0; clr1 = 1'b0;

      // Combinational path with clock idle and reset undriven.
      for (int i = 0; i < 4; i++) begin
         {a1, b1} = 2'(i);
         #10;
         chk("tt_1bit", 32'({sum1, carry1}), 32'(tt_exp[i]));
      end
      a8 = 8'hF0; b8 = 8'h3C;
      #10;
      chk("vec_sum8",   32'(sum8),   32'h0000_00CC);
      chk("vec_carry8", 32'(carry8), 32'h0000_0030);

      rst = 1'b1;
      #1;
      chk("rst_sq8",  32'(sq8),  32'h0);
      chk("rst_ov8",  32'(ov8),  32'h0);
      chk("rst_cnt8", 32'(cnt8), 32'h0);
      chk("rst_ov1",  32'(ov1),  32'h0);
      run = 1'b1;
      step(); step();
      rst = 1'b0;
      chk_en = 1'b1;

      // Registered path, 1-bit instance.
      a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
      step();
      chk("reg_sq1",  32'(sq1),  32'h0);
      chk("reg_cq1",  32'(cq1),  32'h1);
      chk("reg_ov1",  32'(ov1),  32'h1);
      a1 = 1'b0; b1 = 1'b1; v1 = 1'b0;
      step();
      chk("hold_ov1", 32'(ov1),  32'h0);
      chk("hold_sq1", 32'(sq1),  32'h0);
      chk("hold_cq1", 32'(cq1),  32'h1);

      // Counter: five operands, three with a carry.
      for (int i = 0; i < 5; i++) begin
         a8 = ca[i]; b8 = cb[i]; v8 = 1'b1;
         step();
      end
      v8 = 1'b0;
      chk("cnt8_three", 32'(cnt8), 32'd3);
      a8 = 8'h80; b8 = 8'h80; v8 = 1'b1; clr8 = 1'b1;
      step();
      clr8 = 1'b0; v8 = 1'b0;
      chk("cnt8_clr_wins", 32'(cnt8), 32'd0);
      chk("reg_carry8",    32'(cq8),  32'h80);

      // Saturation on the 2-bit counter.
      clr1 = 1'b1;
      step();
      clr1 = 1'b0;
      a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
      for (int i = 0; i < 5; i++) step();
      chk("sat_cnt1", 32'(cnt1), 32'd3);
      step();
      v1 = 1'b0;
      chk("sat_hold1", 32'(cnt1), 32'd3);

      // Async reset mid-operation.
      a8 = 8'hFF; b8 = 8'hFF; v8 = 1'b1;
      step();
      #1;
      rst = 1'b1;
      #1;
      chk("arst_sq8",  32'(sq8),  32'h0);
      chk("arst_cq8",  32'(cq8),  32'h0);
      chk("arst_ov8",  32'(ov8),  32'h0);
      chk("arst_cnt8", 32'(cnt8), 32'h0);
      chk("arst_cnt1", 32'(cnt1), 32'h0);
      a8 = 8'h0F; b8 = 8'h03;
      #1;
      chk("arst_sum8",   32'(sum8),   32'h0C);
      chk("arst_carry8", 32'(carry8), 32'h03);
      step();
      rst = 1'b0;
      chk("post_rst_ov8", 32'(ov8), 32'h0);
      step();
      chk("first_after_rst_ov8", 32'(ov8), 32'h1);
      chk("first_after_rst_cq8", 32'(cq8), 32'h03);
      v8 = 1'b0;
      step(); step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/half_add.md
# half_add

Bank of WIDTH independent half-adder cells with a combinational result path and a registered, valid-qualified result path. It is the leaf arithmetic primitive under the team's adder blocks: the combinational outputs feed ripple and carry-lookahead chains, and the registered outputs feed pipelined datapaths. A saturating carry-event counter supports coverage and debug.

## Interface
Parameters:
- WIDTH, 1, number of independent half-adder bit cells.
- CNT_W, 16, width of the carry-event counter.

Ports:
- clk  input  1  single clock; all registers are rising-edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sum  output  WIDTH  combinational sum, a XOR b per bit.
- carry  output  WIDTH  combinational carry, a AND b per bit.
- in_valid  input  1  qualifies a/b for the registered path.
- sum_q  output  WIDTH  registered sum.
- carry_q  output  WIDTH  registered carry.
- out_valid  output  1  sum_q/carry_q hold a valid result.
- carry_cnt  output  CNT_W  saturating count of accepted operands with any carry bit set.
- cnt_clr  input  1  synchronous clear of carry_cnt.

## Operation
- Combinational path: sum[i] = a[i] ^ b[i]; carry[i] = a[i] & b[i], for each i. This path is purely combinational and is independent of clk, rst, and in_valid. It is valid with clk idle and rst undriven.
- Truth table per bit (a,b -> sum,carry): 00->0,0; 01->1,0; 10->1,0; 11->0,1.
- Registered path: on a clk edge with in_valid=1, sum_q and carry_q take the combinational values and out_valid is set to 1. With in_valid=0, out_valid is set to 0 and sum_q/carry_q hold their previous values.
- Carry counter: on a clk edge with in_valid=1 and |carry=1, carry_cnt increments by 1. It saturates at all-ones and does not wrap.
- cnt_clr has priority over increment: when cnt_clr=1, carry_cnt becomes 0 regardless of in_valid.
- There is no backpressure. Every valid input is accepted.

## Timing
- Combinational outputs: zero-cycle latency; they settle within one propagation delay of an a or b change.
- Registered outputs: one-cycle latency from an in_valid edge to out_valid.
- Reset: rst=1 immediately forces sum_q=0, carry_q=0, out_valid=0, and carry_cnt=0, without waiting for a clock edge. The combinational sum/carry are unaffected by reset.
- Reset mid-operation: any in-flight valid result is discarded. The first valid result after reset appears one edge after rst deasserts with in_valid=1.
- Simultaneous cnt_clr and a carry event on the same edge: the counter ends at 0.
- At saturation, a further carry event leaves carry_cnt at 2^CNT_W-1.

## Structure
- Shared package half_add_pkg holds the default WIDTH and CNT_W constants and a result typedef struct {sum, carry}.
- A natural sub-module is half_add_cell, a one-bit combinational half adder. Generate WIDTH instances of it.
- The top level adds the output registers, the valid flop, and the saturating counter.

## Test plan
- Exhaustive combinational check, WIDTH=1, rst and clk undriven, 10 ns per step: (a,b)=00,01,10,11 -> (sum,carry)=00,10,10,01.
- Registered path, WIDTH=1: in_valid=1 with a=1,b=1 -> one edge later sum_q=0, carry_q=1, out_valid=1. The next edge with in_valid=0 -> out_valid=0 and sum_q/carry_q hold.
- Async reset: assert rst between clock edges -> sum_q, carry_q, out_valid, and carry_cnt all read 0 before the next edge, while sum/carry still track a/b.
- Counter: 5 valid operands, 3 with a carry -> carry_cnt=3. Then cnt_clr together with a carry event -> carry_cnt=0.
- Saturation, CNT_W=2: 5 valid carry events -> carry_cnt=3 and stays 3.
- Vector, WIDTH=8: a=8'hF0, b=8'h3C -> sum=8'hCC, carry=8'h30.
